// File: rtl/seq_divider_32b.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, fixed WIDTH-cycle latency.
// Operands are latched on an accepted start; results and the divide-by-zero flag hold until the next one.
module seq_divider_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, q_r, m_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   a_ext, trial;
    logic [WIDTH-1:0] a_nxt, q_nxt;

    // The shifted partial remainder keeps the bit pushed out of A, so divisors
    // with the MSB set still compare correctly.
    assign a_ext = {a_r, q_r[WIDTH-1]};
    assign trial = a_ext - {1'b0, m_r};

    always_comb begin
        a_nxt = trial[WIDTH] ? a_ext[WIDTH-1:0] : trial[WIDTH-1:0];
        q_nxt = {q_r[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            q_r         <= '0;
            m_r         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            a_r         <= '0;
                            q_r         <= dividend;
                            m_r         <= divisor;
                            cnt         <= CNT_LAST;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    a_r <= a_nxt;
                    q_r <= q_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= q_nxt;
                        remainder <= a_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_32b.sv
// Self-checking bench for seq_divider_32b: directed scenarios plus a randomized
// comparison against plain a/b, a%b arithmetic.
module tb_seq_divider_32b;

    localparam int W   = 32;
    localparam int LAT = W;  // start-sampling edge to the edge that raises done

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int passed = 0;

    seq_divider_32b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: division by zero saturates the quotient and passes the dividend through.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Issues one operation and returns edges from the sampling edge to done (-1 on timeout),
    // then steps past DONE so the divider is idle again.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 0; n <= LAT + 8; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (done) begin lat = n; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({busy, done, div_by_zero} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); else passed++;
        checks++; if ({quotient, remainder} !== '0) $display("FAIL reset_results got %h/%h want 0/0", quotient, remainder); else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, done} !== 2'b00) $display("FAIL post_reset_idle got %b want 00", {busy, done}); else passed++;
    endtask

    task automatic test_basic();
        int busy_cnt, lat;
        @(negedge clk);
        dividend = 100; divisor = 7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; busy_cnt = 0; lat = -1;
        for (int n = 0; n <= LAT + 8; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (busy) busy_cnt++;
            if (done && lat < 0) lat = n;
        end
        checks++; if (lat !== LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT); else passed++;
        checks++; if (busy_cnt !== LAT + 1) $display("FAIL basic_busy_cycles got %0d want %0d", busy_cnt, LAT + 1); else passed++;
        checks++; if (quotient !== 32'd14 || remainder !== 32'd2) $display("FAIL basic_100_7 got q=%0d r=%0d want q=14 r=2", quotient, remainder); else passed++;
        checks++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz got %b want 0", div_by_zero); else passed++;
    endtask

    task automatic test_extremes();
        int lat;
        run_op(32'hFFFF_FFFF, 32'd1, lat);
        checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) $display("FAIL max_div_1 got q=%h r=%h want q=ffffffff r=0", quotient, remainder); else passed++;
        checks++; if (lat !== LAT) $display("FAIL max_div_1_latency got %0d want %0d", lat, LAT); else passed++;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++; if (quotient !== 32'd1 || remainder !== 32'd0) $display("FAIL max_div_max got q=%h r=%h want q=1 r=0", quotient, remainder); else passed++;
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(32'd5, 32'd0, lat);
        // DONE is entered on the sampling edge itself, so done is visible right after it.
        checks++; if (lat !== 0) $display("FAIL dbz_latency got %0d want 0", lat); else passed++;
        checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) $display("FAIL dbz_5_0 got q=%h r=%0d z=%b want q=ffffffff r=5 z=1", quotient, remainder, div_by_zero); else passed++;
        run_op(32'd9, 32'd3, lat);
        checks++; if (quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0) $display("FAIL after_dbz_9_3 got q=%0d r=%0d z=%b want q=3 r=0 z=0", quotient, remainder, div_by_zero); else passed++;
    endtask

    task automatic test_mid_calc();
        int lat;
        run_op(32'd3, 32'd10, lat);
        checks++; if (quotient !== 32'd0 || remainder !== 32'd3) $display("FAIL small_3_10 got q=%0d r=%0d want q=0 r=3", quotient, remainder); else passed++;
        @(negedge clk);
        dividend = 3; divisor = 10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = -1;
        for (int n = 0; n <= LAT + 8; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (n == 5) begin dividend = 77; divisor = 4; start = 1'b1; end
            if (n == 6) start = 1'b0;
            if (done) begin lat = n; break; end
        end
        checks++; if (lat !== LAT) $display("FAIL midcalc_latency got %0d want %0d", lat, LAT); else passed++;
        checks++; if (quotient !== 32'd0 || remainder !== 32'd3) $display("FAIL midcalc_result got q=%0d r=%0d want q=0 r=3", quotient, remainder); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat, done_seen;
        @(negedge clk);
        dividend = 1000; divisor = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, div_by_zero} !== 3'b000 || {quotient, remainder} !== '0) $display("FAIL abort_outputs got b=%b d=%b z=%b q=%h r=%h want all 0", busy, done, div_by_zero, quotient, remainder); else passed++;
        done_seen = 0;
        repeat (3) begin @(posedge clk); #1; if (done) done_seen++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (LAT + 4) begin @(posedge clk); #1; if (done || busy) done_seen++; end
        checks++; if (done_seen !== 0) $display("FAIL abort_no_done got %0d active samples want 0", done_seen); else passed++;
        run_op(32'd1000, 32'd3, lat);
        checks++; if (quotient !== 32'd333 || remainder !== 32'd1) $display("FAIL abort_rerun got q=%0d r=%0d want q=333 r=1", quotient, remainder); else passed++;
    endtask

    task automatic test_start_held();
        int e1, e2;
        e1 = -1; e2 = -1;
        @(negedge clk);
        dividend = 50; divisor = 5; start = 1'b1;
        for (int e = 1; e <= 3 * LAT; e++) begin
            @(posedge clk); #1;
            if (done && e1 < 0) begin
                e1 = e;
                checks++; if (quotient !== 32'd10 || remainder !== 32'd0) $display("FAIL held_50_5 got q=%0d r=%0d want q=10 r=0", quotient, remainder); else passed++;
                dividend = 51;  // offered while still in DONE; picked up at the following IDLE cycle
            end else if (done && e2 < 0) begin
                e2 = e;
                start = 1'b0;
                checks++; if (quotient !== 32'd10 || remainder !== 32'd1) $display("FAIL held_51_5 got q=%0d r=%0d want q=10 r=1", quotient, remainder); else passed++;
                break;
            end
        end
        start = 1'b0;
        checks++; if (e1 !== LAT + 1) $display("FAIL held_first_done got edge %0d want %0d", e1, LAT + 1); else passed++;
        // One DONE cycle and one IDLE cycle separate consecutive operations.
        checks++; if (e2 - e1 !== LAT + 2) $display("FAIL held_spacing got %0d want %0d", e2 - e1, LAT + 2); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic ez;
        int lat, mode;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: b = 0;
                1: b = $urandom_range(1, 16);
                2: a = $urandom_range(0, 100);
                3: b = b | 32'h8000_0000;
                4: a = 0;
                default: ;
            endcase
            ref_div(a, b, eq, er, ez);
            run_op(a, b, lat);
            checks++; if (quotient !== eq || remainder !== er) $display("FAIL rand_%0d %h/%h got q=%h r=%h want q=%h r=%h", i, a, b, quotient, remainder, eq, er); else passed++;
            checks++; if (div_by_zero !== ez) $display("FAIL rand_dbz_%0d got %b want %b", i, div_by_zero, ez); else passed++;
            checks++; if (lat !== (ez ? 0 : LAT)) $display("FAIL rand_latency_%0d got %0d want %0d", i, lat, ez ? 0 : LAT); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_mid_calc();
        test_reset_abort();
        test_start_held();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
